alu_seq_param: RTL

//  Parametrised, registered multi-cycle ALU; successor to the 4-bit select-driven ALU.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq_logic.sv | 27 ++
 rtl/alu_seq_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential parametrised ALU.
package alu_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOTA = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD3 = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_ROTL = 3'b101;
    localparam logic [OP_W-1:0] OP_ZERO = 3'b110;
    localparam logic [OP_W-1:0] OP_ONES = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD2 = 2'd1,
        S_ROT  = 2'd2
    } state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_seq_logic.sv
// Combinational single-cycle results (NOT/AND/OR/XOR/ZERO/ONES) for the sequential ALU.
module alu_seq_logic
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [OP_W-1:0]  sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_c
);

    // Select the single-cycle result; multi-cycle opcodes are handled by the top level
    always_comb begin
        result_c = '0;
        case (sel)
            OP_NOTA: result_c = ~a;
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_ZERO: result_c = '0;
            OP_ONES: result_c = '1;
            default: result_c = '0;
        endcase
    end

endmodule : alu_seq_logic

// File: rtl/alu_seq_param.sv
// Registered multi-cycle ALU: start/busy/done handshake, two-cycle 3-operand add,
// bit-serial rotate-through-carry with programmable amount.
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  Select,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] RegOut,
    output logic             Carryout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned AMT_W = $clog2(WIDTH);
    localparam int unsigned S1_W  = WIDTH + 1;
    localparam int unsigned SUM_W = WIDTH + 2;

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   regout_q, regout_d;
    logic               carry_q,  carry_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [S1_W-1:0]    s1_q,     s1_d;
    logic [WIDTH-1:0]   c_q,      c_d;
    logic [AMT_W-1:0]   cnt_q,    cnt_d;

    logic [WIDTH-1:0]   logic_res_c;
    logic [SUM_W-1:0]   sum2_c;
    logic               accept_c;

    // Single-cycle results computed from the operands as sampled at the accept edge
    alu_seq_logic #(
        .WIDTH (WIDTH)
    ) u_logic (
        .sel      (Select),
        .a        (A),
        .b        (B),
        .result_c (logic_res_c)
    );

    assign accept_c = start && !busy_q;
    assign sum2_c   = SUM_W'(s1_q) + SUM_W'(c_q);

    // Next-state, datapath and handshake logic
    always_comb begin
        state_d  = state_q;
        regout_d = regout_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        s1_d     = s1_q;
        c_d      = c_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (accept_c) begin
                    case (Select)
                        OP_ADD3: begin
                            // First adder stage; C is kept for the second stage
                            s1_d    = S1_W'(A) + S1_W'(B);
                            c_d     = C;
                            busy_d  = 1'b1;
                            state_d = S_ADD2;
                        end
                        OP_ROTL: begin
                            regout_d = A;
                            carry_d  = C[0];
                            cnt_d    = B[AMT_W-1:0];
                            if (B[AMT_W-1:0] != '0) begin
                                busy_d  = 1'b1;
                                state_d = S_ROT;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: begin
                            regout_d = logic_res_c;
                            carry_d  = 1'b0;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_ADD2: begin
                // Carry flag is set if either of the two upper sum bits is set
                regout_d = sum2_c[WIDTH-1:0];
                carry_d  = |sum2_c[SUM_W-1:WIDTH];
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            S_ROT: begin
                // One rotate-through-carry step per cycle
                {carry_d, regout_d} = {regout_q, carry_q};
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            regout_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s1_q     <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            regout_q <= regout_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            s1_q     <= s1_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
        end
    end

    assign RegOut   = regout_q;
    assign Carryout = carry_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : alu_seq_param
